// File: rtl/instr_pack.sv
// Shared definitions for the register_file_p slice: operation encoding and
// the index of z, the branch/jump target register.
package instr_pack;

    typedef enum logic [3:0] {
        NOP    = 4'd0,
        MOV    = 4'd1,
        INCR   = 4'd2,
        DECR   = 4'd3,
        LIT_LO = 4'd4,
        LIT_HI = 4'd5,
        BIZ    = 4'd6,
        BNZ    = 4'd7,
        JMP    = 4'd8,
        CALL   = 4'd9,
        RET    = 4'd10
    } reg_op_p_t;

    localparam int NREG_DEF = 16;

    // z is always the highest-numbered register of the file
    function automatic int z_index(input int nreg);
        return nreg - 1;
    endfunction

    localparam int Z_IDX = NREG_DEF - 1;

endpackage

// File: rtl/register_file_p_ret_stack.sv
// Return-address stack for register_file_p: LIFO of program counter values
// with registered full/empty flags; push when full and pop when empty are ignored.
module ret_stack #(
    parameter int STK_D = 4,
    parameter int PC_W  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty
);

    localparam int CNT_W = $clog2(STK_D + 1);
    localparam int AW    = (STK_D > 1) ? $clog2(STK_D) : 1;

    logic [PC_W-1:0]  mem_r [STK_D];
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             full_r;
    logic             empty_r;
    logic [AW-1:0]    wr_ptr_s;
    logic [AW-1:0]    rd_ptr_s;

    assign wr_ptr_s = cnt_r[AW-1:0];
    assign rd_ptr_s = wr_ptr_s - AW'(1'b1);
    assign top      = mem_r[rd_ptr_s];
    assign full     = full_r;
    assign empty    = empty_r;

    // Next occupancy; push and pop are never requested together
    always_comb begin
        cnt_next_s = cnt_r;
        if (push && !full_r) begin
            cnt_next_s = cnt_r + CNT_W'(1'b1);
        end else if (pop && !empty_r) begin
            cnt_next_s = cnt_r - CNT_W'(1'b1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Stack storage, occupancy and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STK_D; i++) begin
                mem_r[i] <= {PC_W{1'b0}};
            end
            cnt_r   <= {CNT_W{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (push && !full_r) begin
                mem_r[wr_ptr_s] <= push_data;
            end
            cnt_r   <= cnt_next_s;
            full_r  <= (cnt_next_s == CNT_W'(STK_D));
            empty_r <= (cnt_next_s == {CNT_W{1'b0}});
        end
    end

endmodule

// File: rtl/register_file_p.sv
// Register file with program counter and return stack for a small sequencer.
// Register 0 reads as zero; the top register z holds branch/jump/literal targets.
module register_file_p
    import instr_pack::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 16,
    parameter int PC_W   = 10,
    parameter int STK_D  = 4
) (
    input  logic                    clk,
    input  logic                    start_n,
    input  logic                    stall,
    input  reg_op_p_t               reg_op,
    input  logic [$clog2(NREG)-1:0] reg_src,
    input  logic [$clog2(NREG)-1:0] reg_dst,
    input  logic [3:0]              instr_o,
    input  logic                    load_en,
    input  logic [DATA_W-1:0]       load_data,
    input  logic                    stor_en,
    output logic [DATA_W-1:0]       stor_data,
    output logic [PC_W-1:0]         rp,
    output logic                    stk_full,
    output logic                    stk_empty,
    output logic                    stk_err
);

    localparam int IDX_W = $clog2(NREG);
    localparam logic [IDX_W-1:0] Z_SEL = IDX_W'(z_index(NREG));

    logic [DATA_W-1:0] regs_r [NREG];
    logic [PC_W-1:0]   rp_r;
    logic              stk_err_r;

    logic [DATA_W-1:0] src_val_s;
    logic [DATA_W-1:0] z_s;
    logic [DATA_W-1:0] step_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic              wr_en_s;
    logic [PC_W-1:0]   rp_inc_s;
    logic [PC_W-1:0]   jmp_tgt_s;
    logic [PC_W-1:0]   br_tgt_s;
    logic [PC_W-1:0]   rp_next_s;
    logic [PC_W-1:0]   stk_top_s;
    logic              push_s;
    logic              pop_s;
    logic              err_set_s;

    assign src_val_s = (reg_src == {IDX_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[reg_src];
    assign z_s       = regs_r[Z_SEL];
    assign step_s    = DATA_W'(instr_o[2:0]) + DATA_W'(1'b1);
    assign rp_inc_s  = rp_r + PC_W'(1'b1);
    assign jmp_tgt_s = PC_W'({instr_o[1:0], z_s});
    assign stor_data = stor_en ? src_val_s : {DATA_W{1'b0}};
    assign rp        = rp_r;
    assign stk_err   = stk_err_r;

    // Conditional branch target: z replaces the low DATA_W bits of rp
    always_comb begin
        br_tgt_s                = rp_r;
        br_tgt_s[DATA_W-1:0]    = z_s;
    end

    // Register write selection; a memory load overrides the op's own write
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = reg_dst;
        wr_data_s = {DATA_W{1'b0}};
        if (load_en) begin
            wr_en_s   = 1'b1;
            wr_data_s = load_data;
        end else begin
            case (reg_op)
                MOV: begin
                    wr_en_s   = 1'b1;
                    wr_data_s = (reg_src == reg_dst) ? {DATA_W{1'b0}} : src_val_s;
                end
                INCR: begin
                    wr_en_s   = 1'b1;
                    wr_data_s = src_val_s + step_s;
                end
                DECR: begin
                    wr_en_s   = 1'b1;
                    wr_data_s = src_val_s - step_s;
                end
                LIT_LO: begin
                    wr_en_s        = 1'b1;
                    wr_idx_s       = Z_SEL;
                    wr_data_s      = z_s;
                    wr_data_s[3:0] = instr_o;
                end
                LIT_HI: begin
                    wr_en_s        = 1'b1;
                    wr_idx_s       = Z_SEL;
                    wr_data_s      = z_s;
                    wr_data_s[7:4] = instr_o;
                end
                default: begin
                    wr_en_s = 1'b0;
                end
            endcase
        end
    end

    // Program counter sequencing and return-stack requests
    always_comb begin
        rp_next_s = rp_inc_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        err_set_s = 1'b0;
        case (reg_op)
            BIZ:     rp_next_s = (src_val_s == {DATA_W{1'b0}}) ? br_tgt_s : rp_inc_s;
            BNZ:     rp_next_s = (src_val_s != {DATA_W{1'b0}}) ? br_tgt_s : rp_inc_s;
            JMP:     rp_next_s = jmp_tgt_s;
            CALL: begin
                if (!stk_full) begin
                    push_s    = 1'b1;
                    rp_next_s = jmp_tgt_s;
                end else begin
                    err_set_s = 1'b1;
                end
            end
            RET: begin
                if (!stk_empty) begin
                    pop_s     = 1'b1;
                    rp_next_s = stk_top_s;
                end else begin
                    err_set_s = 1'b1;
                end
            end
            default: rp_next_s = rp_inc_s;
        endcase
    end

    // Architectural state; everything holds while stalled
    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            rp_r      <= {PC_W{1'b0}};
            stk_err_r <= 1'b0;
        end else if (!stall) begin
            if (wr_en_s && (wr_idx_s != {IDX_W{1'b0}})) begin
                regs_r[wr_idx_s] <= wr_data_s;
            end
            rp_r      <= rp_next_s;
            stk_err_r <= stk_err_r | err_set_s;
        end
    end

    ret_stack #(
        .STK_D (STK_D),
        .PC_W  (PC_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (start_n),
        .push      (push_s & ~stall),
        .pop       (pop_s & ~stall),
        .push_data (rp_inc_s),
        .top       (stk_top_s),
        .full      (stk_full),
        .empty     (stk_empty)
    );

endmodule
